// File: rtl/cfg_chain_loader_pkg.sv
// cfg_chain_loader_pkg: shared state encoding and sizing helpers for the config chain loader.
package cfg_chain_loader_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, SHIFT, DONE} state_e;

    function automatic int word_count(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/cfg_chain_loader_if.sv
// cfg_chain_loader_if: host-side word stream and chain-side control signals of the loader.
interface cfg_chain_loader_if #(parameter int WORD_W = 32);

    logic              start;
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_ready;
    logic              cfg_bit;
    logic              cfg_shift;
    logic              cfg_reset;
    logic              busy;
    logic              done;

    modport master (
        output start, word_valid, word_data,
        input  word_ready, cfg_bit, cfg_shift, cfg_reset, busy, done
    );

    modport slave (
        input  start, word_valid, word_data,
        output word_ready, cfg_bit, cfg_shift, cfg_reset, busy, done
    );

endinterface

// File: rtl/cfg_chain_loader_piso.sv
// cfg_piso: parallel-load, LSB-first serial-out register that stops on the last valid bit.
module cfg_piso #(
    parameter  int WORD_W = 32,
    localparam int CW     = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [CW-1:0]     len_i,
    input  logic [WORD_W-1:0] data_i,
    output logic              bit_o,
    output logic              last_o
);

    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [CW-1:0]     cnt_q, cnt_d, len_q, len_d;
    logic              adv;

    // The final bit is not shifted out so bit_o holds it while the chain is idle.
    assign adv    = shift_i && !last_o;
    assign bit_o  = sreg_q[0];
    assign last_o = cnt_q == len_q;

    always_comb begin
        sreg_d = load_i ? data_i : adv ? sreg_q >> 1 : sreg_q;
        cnt_d  = load_i ? CW'(1) : adv ? cnt_q + 1'b1 : cnt_q;
        len_d  = load_i ? len_i : len_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            len_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
            len_q  <= len_d;
        end
    end

endmodule

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: clears the PE config chain, then serializes CHAIN_LEN bits from a word stream.
module cfg_chain_loader
    import cfg_chain_loader_pkg::*;
#(
    parameter int WORD_W       = 32,
    parameter int CHAIN_LEN    = 1024,
    parameter int CLEAR_CYCLES = 2
) (
    input logic              clk,
    input logic              reset,
    cfg_chain_loader_if.slave bus
);

    localparam int BW = $clog2(CHAIN_LEN + 1);
    localparam int CW = $clog2(WORD_W + 1);
    localparam int KW = CLEAR_CYCLES > 1 ? $clog2(CLEAR_CYCLES) : 1;

    state_e        state_q, state_d;
    logic [BW-1:0] sent_q, sent_d, remain;
    logic [KW-1:0] clr_q, clr_d;
    logic [CW-1:0] len;
    logic          accept, last;

    assign remain = BW'(CHAIN_LEN) - sent_q;
    assign len    = int'(remain) >= WORD_W ? CW'(WORD_W) : CW'(remain);
    assign accept = state_q == LOAD && bus.word_valid;

    always_comb begin
        state_d = state_q;
        sent_d  = sent_q;
        clr_d   = clr_q;
        unique case (state_q)
            IDLE, DONE: if (bus.start) begin
                state_d = CLEAR;
                clr_d   = KW'(CLEAR_CYCLES - 1);
                sent_d  = '0;
            end
            CLEAR: begin
                state_d = clr_q == '0 ? LOAD : CLEAR;
                clr_d   = clr_q == '0 ? clr_q : clr_q - 1'b1;
            end
            LOAD: state_d = bus.word_valid ? SHIFT : LOAD;
            SHIFT: begin
                sent_d  = sent_q + 1'b1;
                state_d = !last ? SHIFT : sent_d == BW'(CHAIN_LEN) ? DONE : LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sent_q  <= '0;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            sent_q  <= sent_d;
            clr_q   <= clr_d;
        end
    end

    cfg_piso #(.WORD_W(WORD_W)) u_piso (
        .clk     (clk),
        .reset   (reset),
        .load_i  (accept),
        .shift_i (state_q == SHIFT),
        .len_i   (len),
        .data_i  (bus.word_data),
        .bit_o   (bus.cfg_bit),
        .last_o  (last)
    );

    // Every control output is a pure decode of the state register.
    assign bus.word_ready = state_q == LOAD;
    assign bus.cfg_shift  = state_q == SHIFT;
    assign bus.cfg_reset  = state_q == CLEAR;
    assign bus.busy       = state_q inside {CLEAR, LOAD, SHIFT};
    assign bus.done       = state_q == DONE;

endmodule
